// File: rtl/e203_exu_decq.sv
// e203_exu_decq: decode queue between IFU and EXU dispatch.
// Each fetched instruction is predecoded as it enters. The register
// indices, enables, branch class, illegal flag and a MULH->MUL fusion
// hint are stored next to the raw fetch data.
// Optional feature macro: E203_DECQ_BYPASS_EN. When it is defined, an
// empty queue forwards the incoming instruction straight to the outputs
// in the same cycle.
module e203_exu_decq #(
  parameter int DEPTH       = 4,
  parameter int PC_SIZE     = 32,
  parameter int RFIDX_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [31:0]                i_instr,
  input  logic [PC_SIZE-1:0]         i_pc,
  input  logic                       i_prdt_taken,
  input  logic                       i_misalgn,
  input  logic                       i_buserr,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [31:0]                o_instr,
  output logic [PC_SIZE-1:0]         o_pc,
  output logic                       o_prdt_taken,
  output logic                       o_misalgn,
  output logic                       o_buserr,
  output logic [RFIDX_WIDTH-1:0]     o_rs1idx,
  output logic [RFIDX_WIDTH-1:0]     o_rs2idx,
  output logic [RFIDX_WIDTH-1:0]     o_rdidx,
  output logic                       o_rs1en,
  output logic                       o_rs2en,
  output logic                       o_rdwen,
  output logic                       o_jal,
  output logic                       o_jalr,
  output logic                       o_bxx,
  output logic                       o_ilegl,
  output logic                       o_muldiv_b2b,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BXX    = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [31:0]            instr;
    logic [PC_SIZE-1:0]     pc;
    logic                   prdt_taken;
    logic                   misalgn;
    logic                   buserr;
    logic [RFIDX_WIDTH-1:0] rs1idx;
    logic [RFIDX_WIDTH-1:0] rs2idx;
    logic [RFIDX_WIDTH-1:0] rdidx;
    logic                   rs1en;
    logic                   rs2en;
    logic                   rdwen;
    logic                   jal;
    logic                   jalr;
    logic                   bxx;
    logic                   ilegl;
    logic                   b2b;
  } entry_t;

  // The fusion hint looks only at the raw 5-bit instruction fields.
  typedef struct packed {
    logic       mulh;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } hist_t;

  entry_t        mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  hist_t         hist_q, hist_d;

  entry_t        dec;
  hist_t         cur_hist;
  entry_t        head;
  logic          full, empty, byp, push, pop, accept;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign i_ready = !full && !flush;
  assign accept  = i_valid && i_ready;

`ifdef E203_DECQ_BYPASS_EN
  assign byp = empty && i_valid && !flush;
`else
  assign byp = 1'b0;
`endif

  // A bypassed instruction that is consumed in the same cycle never takes a slot.
  assign push    = accept && !(byp && o_ready);
  assign pop     = !empty && o_ready && !flush;
  assign o_valid = !empty || byp;
  assign count   = wptr_q - rptr_q;

  // Predecode the incoming instruction and match it against the history for the fusion hint.
  always_comb begin
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal, is_jal, is_jalr, is_bxx, is_lui, is_auipc, is_store, is_op, is_mul;
    op       = i_instr[6:0];
    f3       = i_instr[14:12];
    f7       = i_instr[31:25];
    legal    = (i_instr[1:0] == 2'b11);
    is_jal   = (op == OP_JAL);
    is_jalr  = (op == OP_JALR);
    is_bxx   = (op == OP_BXX);
    is_lui   = (op == OP_LUI);
    is_auipc = (op == OP_AUIPC);
    is_store = (op == OP_STORE);
    is_op    = (op == OP_OP);
    is_mul   = is_op && (f7 == F7_MULDIV) && (f3 == 3'b000);

    dec            = '0;
    dec.instr      = i_instr;
    dec.pc         = i_pc;
    dec.prdt_taken = i_prdt_taken;
    dec.misalgn    = i_misalgn;
    dec.buserr     = i_buserr;
    dec.rs1idx     = RFIDX_WIDTH'(i_instr[19:15]);
    dec.rs2idx     = RFIDX_WIDTH'(i_instr[24:20]);
    dec.rdidx      = RFIDX_WIDTH'(i_instr[11:7]);
    dec.ilegl      = !legal;
    dec.rs1en      = legal && !(is_lui || is_auipc || is_jal);
    dec.rs2en      = legal && (is_bxx || is_store || is_op);
    dec.rdwen      = legal && !(is_bxx || is_store) && (i_instr[11:7] != 5'd0);
    dec.jal        = legal && is_jal;
    dec.jalr       = legal && is_jalr;
    dec.bxx        = legal && is_bxx;
    // Hint only when the MULH wrote neither of its own sources, so MUL can reuse its operands.
    dec.b2b        = is_mul && hist_q.mulh
                     && (i_instr[19:15] == hist_q.rs1) && (i_instr[24:20] == hist_q.rs2)
                     && (hist_q.rd != hist_q.rs1) && (hist_q.rd != hist_q.rs2);

    cur_hist.mulh  = is_op && (f7 == F7_MULDIV) && (f3 inside {3'b001, 3'b010, 3'b011});
    cur_hist.rs1   = i_instr[19:15];
    cur_hist.rs2   = i_instr[24:20];
    cur_hist.rd    = i_instr[11:7];
  end

  // The head comes from storage, or from the predecoder when an empty queue is bypassed.
  always_comb begin
    head = byp ? dec : mem_q[rptr_q[AW-1:0]];
  end

  assign o_instr      = head.instr;
  assign o_pc         = head.pc;
  assign o_prdt_taken = head.prdt_taken;
  assign o_misalgn    = head.misalgn;
  assign o_buserr     = head.buserr;
  assign o_rs1idx     = head.rs1idx;
  assign o_rs2idx     = head.rs2idx;
  assign o_rdidx      = head.rdidx;
  assign o_rs1en      = head.rs1en;
  assign o_rs2en      = head.rs2en;
  assign o_rdwen      = head.rdwen;
  assign o_jal        = head.jal;
  assign o_jalr       = head.jalr;
  assign o_bxx        = head.bxx;
  assign o_ilegl      = head.ilegl;
  assign o_muldiv_b2b = head.b2b;

  // Next-state for the pointers and history; flush wins over push and pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    hist_d = hist_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      hist_d = '0;
    end else begin
      if (push)   wptr_d = wptr_q + (AW+1)'(1);
      if (pop)    rptr_d = rptr_q + (AW+1)'(1);
      if (accept) hist_d = cur_hist;
    end
  end

  // Control state register; async reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      hist_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      hist_q <= hist_d;
    end
  end

  // Entry storage; cleared on reset so the outputs of an idle queue read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q[AW-1:0]] <= dec;
    end
  end

endmodule

// File: tb/tb_e203_exu_decq.sv
// Bench for e203_exu_decq: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model.
module tb_e203_exu_decq;
  localparam int DEPTH = 4;
`ifdef E203_DECQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, rst, flush, i_valid, i_ready, i_prdt_taken, i_misalgn, i_buserr;
  logic [31:0] i_instr, i_pc, o_instr, o_pc;
  logic        o_valid, o_ready, o_prdt_taken, o_misalgn, o_buserr;
  logic [4:0]  o_rs1idx, o_rs2idx, o_rdidx;
  logic        o_rs1en, o_rs2en, o_rdwen, o_jal, o_jalr, o_bxx, o_ilegl, o_muldiv_b2b;
  logic [2:0]  count;

  e203_exu_decq #(.DEPTH(DEPTH), .PC_SIZE(32), .RFIDX_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_valid(i_valid), .i_ready(i_ready), .i_instr(i_instr), .i_pc(i_pc),
    .i_prdt_taken(i_prdt_taken), .i_misalgn(i_misalgn), .i_buserr(i_buserr),
    .o_valid(o_valid), .o_ready(o_ready), .o_instr(o_instr), .o_pc(o_pc),
    .o_prdt_taken(o_prdt_taken), .o_misalgn(o_misalgn), .o_buserr(o_buserr),
    .o_rs1idx(o_rs1idx), .o_rs2idx(o_rs2idx), .o_rdidx(o_rdidx),
    .o_rs1en(o_rs1en), .o_rs2en(o_rs2en), .o_rdwen(o_rdwen),
    .o_jal(o_jal), .o_jalr(o_jalr), .o_bxx(o_bxx), .o_ilegl(o_ilegl),
    .o_muldiv_b2b(o_muldiv_b2b), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, pc;
    logic [2:0]  side;   // {prdt_taken, misalgn, buserr}
    logic [14:0] idx;    // {rs1, rs2, rd}
    logic [7:0]  flags;  // {rs1en, rs2en, rdwen, jal, jalr, bxx, ilegl, b2b}
  } exp_t;

  exp_t       q[$];
  logic       h_mulh;
  logic [4:0] h_rs1, h_rs2, h_rd;
  int         n_checks, n_fail;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  // Reference predecode: what the instruction is, then what it reads and writes.
  function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] pc, input logic [2:0] side);
    exp_t e;
    logic [6:0] op;
    logic legal, jal, jalr, bxx, lui, auipc, store, opr, mul;
    logic r1, r2, wr;
    op    = ins[6:0];
    legal = (ins[1:0] == 2'b11);
    jal   = (op == 7'h6F); jalr = (op == 7'h67); bxx = (op == 7'h63);
    lui   = (op == 7'h37); auipc = (op == 7'h17); store = (op == 7'h23); opr = (op == 7'h33);
    mul   = opr && (ins[31:25] == 7'd1) && (ins[14:12] == 3'd0);
    r1 = 1'b1; r2 = 1'b0; wr = 1'b1;
    if (lui || auipc || jal) r1 = 1'b0;
    if (bxx || store || opr) r2 = 1'b1;
    if (bxx || store || ins[11:7] == 5'd0) wr = 1'b0;
    if (!legal) begin r1 = 0; r2 = 0; wr = 0; jal = 0; jalr = 0; bxx = 0; end
    e.instr = ins;
    e.pc    = pc;
    e.side  = side;
    e.idx   = {ins[19:15], ins[24:20], ins[11:7]};
    e.flags = {r1, r2, wr, jal, jalr, bxx, !legal,
               mul && h_mulh && ins[19:15] == h_rs1 && ins[24:20] == h_rs2 && h_rd != h_rs1 && h_rd != h_rs2};
    return e;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    logic [6:0]  ops [8];
    ops = '{7'h6F, 7'h67, 7'h63, 7'h37, 7'h17, 7'h23, 7'h33, 7'h13};
    r = $urandom;
    case ($urandom_range(0, 5))
      0: rnd_instr = r;
      1, 2: rnd_instr = enc_r(7'd1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                              3'($urandom_range(1, 3)), 5'($urandom_range(0, 3)), 7'h33);
      3: rnd_instr = enc_r(7'd1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                           3'd0, 5'($urandom_range(0, 7)), 7'h33);
      4: rnd_instr = {r[31:7], ops[$urandom_range(0, 7)]};
      default: rnd_instr = {r[31:2], 2'($urandom_range(0, 2))};
    endcase
  endfunction

  task automatic clear_model();
    q.delete();
    h_mulh = 1'b0; h_rs1 = '0; h_rs2 = '0; h_rd = '0;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    i_valid = v; i_instr = ins; i_pc = pc; o_ready = ordy; flush = fl;
    i_prdt_taken = 1'($urandom); i_misalgn = 1'($urandom); i_buserr = 1'($urandom);
  endtask

  // Check the cycle's outputs mid-cycle, then advance the model across the clock edge.
  task automatic settle();
    exp_t hd, ent;
    logic exp_rdy, byp, accept, pop;
    @(negedge clk);
    exp_rdy = (q.size() < DEPTH) && !flush;
    byp     = BYP && q.size() == 0 && i_valid && !flush;
    ent     = mk(i_instr, i_pc, {i_prdt_taken, i_misalgn, i_buserr});
    check_eq("i_ready", 64'(i_ready), 64'(exp_rdy));
    check_eq("o_valid", 64'(o_valid), 64'(q.size() > 0 || byp));
    check_eq("count", 64'(count), 64'(q.size()));
    if (q.size() > 0 || byp) begin
      hd = byp ? ent : q[0];
      check_eq("head_instr", 64'(o_instr), 64'(hd.instr));
      check_eq("head_pc", 64'(o_pc), 64'(hd.pc));
      check_eq("head_side", 64'({o_prdt_taken, o_misalgn, o_buserr}), 64'(hd.side));
      check_eq("head_idx", 64'({o_rs1idx, o_rs2idx, o_rdidx}), 64'(hd.idx));
      check_eq("head_flags", 64'({o_rs1en, o_rs2en, o_rdwen, o_jal, o_jalr, o_bxx, o_ilegl, o_muldiv_b2b}),
               64'(hd.flags));
    end
    accept = i_valid && exp_rdy;
    pop    = q.size() > 0 && o_ready && !flush;
    @(posedge clk);
    #1;
    if (flush) clear_model();
    else begin
      if (pop) void'(q.pop_front());
      if (accept) begin
        if (!(byp && o_ready)) q.push_back(ent);
        h_mulh = (i_instr[6:0] == 7'h33) && (i_instr[31:25] == 7'd1) && (i_instr[14:12] inside {3'd1, 3'd2, 3'd3});
        h_rs1 = i_instr[19:15]; h_rs2 = i_instr[24:20]; h_rd = i_instr[11:7];
      end
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    drive(v, ins, pc, ordy, fl);
    settle();
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 1; k++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  localparam logic [31:0] ADDI    = 32'h00500093;
  localparam logic [31:0] MULH_OK = 32'h022091B3;
  localparam logic [31:0] MULH_RD = 32'h022090B3;
  localparam logic [31:0] MUL4    = 32'h02208233;

  initial begin
    int rdy_pct;
    n_checks = 0; n_fail = 0;
    clear_model();
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_o_valid", 64'(o_valid), 64'(0));
    check_eq("rst_count", 64'(count), 64'(0));
    check_eq("rst_i_ready", 64'(i_ready), 64'(1));
    check_eq("rst_data", 64'({o_instr, o_pc}), 64'(0));
    check_eq("rst_flags", 64'({o_rs1en, o_rdwen, o_ilegl, o_muldiv_b2b, o_rdidx}), 64'(0));
    rst = 1'b0;

    // ADDI x1,x0,5 shows up one cycle after the push.
    step(1'b1, ADDI, 32'h80, 1'b0, 1'b0);
    check_eq("addi_valid", 64'(o_valid), 64'(1));
    check_eq("addi_en", 64'({o_rs1en, o_rs2en, o_rdwen}), 64'(3'b101));
    check_eq("addi_rd", 64'(o_rdidx), 64'(1));
    check_eq("addi_count", 64'(count), 64'(1));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill, hold off a fifth push, then drain in order across the pointer wrap.
    for (int k = 0; k < 4; k++) step(1'b1, ADDI, 32'h100 + 4 * k, 1'b0, 1'b0);
    check_eq("full_count", 64'(count), 64'(4));
    check_eq("full_ready", 64'(i_ready), 64'(0));
    step(1'b1, ADDI, 32'h200, 1'b0, 1'b0);
    check_eq("held_count", 64'(count), 64'(4));
    for (int k = 0; k < 4; k++) begin
      check_eq("order_pc", 64'(o_pc), 64'(32'h100 + 4 * k));
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    check_eq("empty_valid", 64'(o_valid), 64'(0));

    // Full with a pop and a push request together: only the pop happens.
    for (int k = 0; k < 4; k++) step(1'b1, ADDI, 32'h300 + 4 * k, 1'b0, 1'b0);
    step(1'b1, ADDI, 32'h400, 1'b1, 1'b0);
    check_eq("fullpop_count", 64'(count), 64'(3));
    check_eq("fullpop_ready", 64'(i_ready), 64'(1));
    check_eq("fullpop_head", 64'(o_pc), 64'(32'h304));
    drain();

    // MULH x3,x1,x2 then MUL x4,x1,x2 fuse; MULH x1,x1,x2 does not.
    step(1'b1, MULH_OK, 32'h500, 1'b0, 1'b0);
    step(1'b1, MUL4, 32'h504, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check_eq("b2b_hit", 64'(o_muldiv_b2b), 64'(1));
    drain();
    step(1'b1, MULH_RD, 32'h510, 1'b0, 1'b0);
    step(1'b1, MUL4, 32'h514, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check_eq("b2b_rdclash", 64'(o_muldiv_b2b), 64'(0));
    drain();

    // Flush with i_valid drops everything, including the MULH history.
    step(1'b1, ADDI, 32'h600, 1'b0, 1'b0);
    step(1'b1, ADDI, 32'h604, 1'b0, 1'b0);
    step(1'b1, MULH_OK, 32'h608, 1'b0, 1'b0);
    step(1'b1, ADDI, 32'h60C, 1'b1, 1'b1);
    check_eq("flush_count", 64'(count), 64'(0));
    check_eq("flush_valid", 64'(o_valid), 64'(0));
    step(1'b1, MUL4, 32'h610, 1'b0, 1'b0);
    check_eq("flush_b2b", 64'(o_muldiv_b2b), 64'(0));
    drain();

    // Empty queue, push with o_ready: bypass consumes it in the same cycle.
    drive(1'b1, ADDI, 32'h700, 1'b1, 1'b0);
    #1;
    check_eq("byp_same_cycle", 64'(o_valid), 64'(BYP));
    settle();
    check_eq("byp_count", 64'(count), 64'(BYP ? 0 : 1));
    check_eq("byp_next_valid", 64'(o_valid), 64'(BYP ? 0 : 1));
    drain();

    // A 16-bit style word is illegal and writes nothing.
    step(1'b1, 32'h00000001, 32'h800, 1'b0, 1'b0);
    check_eq("ilegl", 64'(o_ilegl), 64'(1));
    check_eq("ilegl_rdwen", 64'(o_rdwen), 64'(0));
    drain();

    // Asynchronous reset in the middle of a cycle with entries queued.
    step(1'b1, ADDI, 32'h900, 1'b0, 1'b0);
    step(1'b1, ADDI, 32'h904, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_valid", 64'(o_valid), 64'(0));
    check_eq("arst_count", 64'(count), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    clear_model();

    // Randomized traffic with varying consumer back-pressure.
    rdy_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) rdy_pct = (c / 200) % 3 == 0 ? 15 : ((c / 200) % 3 == 1 ? 50 : 90);
      step(1'($urandom_range(0, 99) < 70), rnd_instr(), $urandom,
           1'($urandom_range(0, 99) < rdy_pct), 1'($urandom_range(0, 99) < 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
